aes_shift_rows_pipe: RTL and testbench
======================================

Name: aes_shift_rows_pipe

Overview:
Parametrised, handshaked ShiftRows / InvShiftRows stage for the AES/Rijndael datapath.
- Supports block widths of Nb = 4, 6 or 8 columns (128/192/256-bit state).
- The direction is selected per transfer by a mode bit.
- Results are held in a 2-entry output buffer, so the stage sustains one block per cycle under valid/ready backpressure.
- Sits between SubBytes and MixColumns in round pipelines, and between InvSubBytes-adjacent stages in decryption.

Parameters:
NB, 4, state columns; legal values 4, 6, 8; any other value is an elaboration error.
BLK_W, 32*NB, derived state width in bits; not overridable.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
in_valid  in  1  input block present.
in_ready  out  1  stage accepts a block this cycle.
in_mode  in  1  0 = ShiftRows (encrypt), 1 = InvShiftRows (decrypt).
in_data  in  BLK_W  state, declared [0:BLK_W-1].
out_valid  out  1  output block present.
out_ready  in  1  downstream accepts.
out_mode  out  1  mode of the block at the output head.
out_data  out  BLK_W  permuted state, [0:BLK_W-1].

Behaviour:
- **Byte mapping:** byte k occupies bits [8k : 8k+7]; byte k = state[row = k mod 4][col = k div 4], column-major, byte 0 MSB-first at bit 0.
- **Row offsets:**
  - Rows 0..3 use offsets 0,1,2,3 for NB = 4 or 6.
  - Rows 0..3 use offsets 0,1,3,4 for NB = 8.
- **Forward permutation:** out[r][c] = in[r][(c + off_r) mod NB].
- **Inverse permutation:** out[r][c] = in[r][(c - off_r + NB) mod NB].
- **Transfer rules:**
  - An input transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready.
  - The permutation is applied combinationally at the input. The permuted data plus in_mode are written into the buffer.
- **Buffer:**
  - 2-entry FIFO with registered head pointer and count (0..2).
  - in_ready = (count != 2), driven from registers only, with no combinational path from out_ready.
  - out_valid = (count != 0).
  - out_data / out_mode are the head entry.
- **Latency:** an accepted block appears at the output on the next clock edge, so it is presented the cycle after acceptance.
- **Throughput:** one block per cycle while out_ready stays high.
- **Simultaneous push and pop:**
  - count = 1: count stays 1, head advances, and the new entry becomes the head next cycle.
  - count = 0: only a push is possible.
  - count = 2: no push is possible because in_ready = 0.
- **Backpressure:** with out_ready low, the head and out_data hold stable. At most 2 blocks are absorbed, after which in_ready drops.
- **Ordering:** blocks leave in acceptance order. Mixed-mode sequences are allowed; each block uses its own mode.
- **Reset (any time, including mid-stream):**
  - count = 0, head pointer = 0, out_valid = 0.
  - in_ready = 1 once rst is released. While rst is asserted, in_ready = 0.
  - out_data and out_mode read as 0.
  - Buffered blocks are discarded.
- **Inputs while not ready:** in_data and in_mode are ignored when in_valid is low or in_ready is low.

Decomposition:
- **Shared package aes_pkg:**
  - BYTE_SIZE = 8.
  - N_ROWS = 4.
  - Function shift_offset(nb, row) returning the row offset.
  - Mode constants MODE_FWD = 0, MODE_INV = 1.
- **Sub-module shift_rows_perm:** combinational, parameter NB, ports mode / data_in / data_out, built with generate loops over row and column.
- **Top:** aes_shift_rows_pipe instantiates shift_rows_perm and implements the 2-entry buffer.

Test Plan:
- NB=4, mode 0, in_data d42711aee0bf98f1b8b45de51e415230, out_ready=1 -> out_data d4bf5d30e0b452aeb84111f11e2798e5 one cycle later, out_mode 0.
- NB=4, mode 1, in_data d4bf5d30e0b452aeb84111f11e2798e5 -> d42711aee0bf98f1b8b45de51e415230. Also: forward then inverse on 16 random blocks -> identity.
- NB=8, mode 0, in_data bytes 00..1f ascending -> column 0 bytes 00,05,0e,13; column 7 bytes 1c,01,0a,0f. Inverse returns 00..1f. NB=6 forward checked the same way against the formula.
- Backpressure: out_ready=0, 3 back-to-back valid blocks -> exactly 2 accepted, in_ready=0 from the cycle after the 2nd acceptance. Release out_ready -> blocks emerge in order, 1 per cycle, with no drop or duplicate.
- Streaming: in_valid=1 and out_ready=1 for 20 cycles with alternating modes -> 20 outputs, each correctly permuted per its own mode, count never above 1.
- Reset with 2 blocks buffered: assert rst between edges -> out_valid falls immediately, without waiting for a clock. After release: in_ready=1, out_valid=0, and a new block is handled normally.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES datapath constants and the ShiftRows row-offset rule.
package aes_pkg;

    localparam int BYTE_SIZE = 8;
    localparam int N_ROWS    = 4;

    typedef enum logic {
        MODE_FWD = 1'b0,
        MODE_INV = 1'b1
    } aes_mode_e;

    // Rijndael offsets: 0,1,2,3 for Nb 4/6; rows 2 and 3 gain one more for Nb 8.
    function automatic int shift_offset(int nb, int row);
        if (nb == 8 && row >= 2) begin
            return row + 1;
        end
        return row;
    endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation over an Nb-column state.
module shift_rows_perm
    import aes_pkg::*;
#(
    parameter int NB = 4
)
(
    input  logic                              mode,
    input  logic [0:BYTE_SIZE*N_ROWS*NB-1]    data_in,
    output logic [0:BYTE_SIZE*N_ROWS*NB-1]    data_out
);

    for (genvar r = 0; r < N_ROWS; r++) begin : g_row
        localparam int OFF = shift_offset(NB, r);
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int FWD_C = (c + OFF) % NB;
            localparam int INV_C = (c - OFF + NB) % NB;
            assign data_out[BYTE_SIZE*(N_ROWS*c+r) +: BYTE_SIZE] =
                (mode == MODE_INV) ? data_in[BYTE_SIZE*(N_ROWS*INV_C+r) +: BYTE_SIZE]
                                   : data_in[BYTE_SIZE*(N_ROWS*FWD_C+r) +: BYTE_SIZE];
        end
    end

endmodule

// File: rtl/aes_shift_rows_pipe.sv
// Handshaked ShiftRows/InvShiftRows stage: permute at the input, hold results in a 2-entry FIFO.
module aes_shift_rows_pipe
    import aes_pkg::*;
#(
    parameter int NB = 4
)
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              in_mode,
    input  logic [0:BYTE_SIZE*N_ROWS*NB-1]    in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_mode,
    output logic [0:BYTE_SIZE*N_ROWS*NB-1]    out_data
);

    localparam int BLK_W = BYTE_SIZE * N_ROWS * NB;

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
    end

    logic [0:BLK_W-1] perm_data;
    logic [0:BLK_W-1] buf_data [2];
    logic [1:0]       buf_mode;
    logic             head_q;
    logic [1:0]       count_q;
    logic             push;
    logic             pop;
    logic             wr_idx;

    shift_rows_perm #(.NB(NB)) u_perm (
        .mode     (in_mode),
        .data_in  (in_data),
        .data_out (perm_data)
    );

    // in_ready depends only on state and rst, never on out_ready.
    always_comb begin
        in_ready  = ~rst & (count_q != 2'd2);
        out_valid = (count_q != 2'd0);
        out_data  = buf_data[head_q];
        out_mode  = buf_mode[head_q];
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
        wr_idx    = head_q ^ (count_q == 2'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q   <= 1'b0;
            count_q  <= '0;
            buf_mode <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                buf_data[i] <= '0;
            end
        end else begin
            if (push) begin
                buf_data[wr_idx] <= perm_data;
                buf_mode[wr_idx] <= in_mode;
            end
            if (pop) begin
                head_q <= ~head_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// Self-checking bench for aes_shift_rows_pipe (NB=4 handshake, NB=6/8 permutation).
module tb_aes_shift_rows_pipe;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, in_mode, out_valid, out_ready, out_mode;
    logic [0:127] in_data, out_data;
    logic         v8, r8, m8, ov8, om8;
    logic [0:255] d8, od8;
    logic         v6, r6, m6, ov6, om6;
    logic [0:191] d6, od6;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_shift_rows_pipe #(.NB(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode),
        .out_data(out_data)
    );

    aes_shift_rows_pipe #(.NB(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .in_mode(m8),
        .in_data(d8), .out_valid(ov8), .out_ready(1'b1), .out_mode(om8), .out_data(od8)
    );

    aes_shift_rows_pipe #(.NB(6)) dut6 (
        .clk(clk), .rst(rst), .in_valid(v6), .in_ready(r6), .in_mode(m6),
        .in_data(d6), .out_valid(ov6), .out_ready(1'b1), .out_mode(om6), .out_data(od6)
    );

    // Reference: each row is rotated left (forward) or right (inverse) by its offset.
    function automatic logic [0:255] ref_shift(int nb, logic inv, logic [0:255] d);
        logic [7:0]   row [8];
        logic [7:0]   t;
        logic [0:255] o;
        int           off;
        o = d;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < nb; c++) row[c] = d[8*(4*c+r) +: 8];
            off = (nb == 8 && r >= 2) ? r + 1 : r;
            repeat (off) begin
                if (!inv) begin
                    t = row[0];
                    for (int c = 0; c < nb - 1; c++) row[c] = row[c+1];
                    row[nb-1] = t;
                end else begin
                    t = row[nb-1];
                    for (int c = nb - 1; c > 0; c--) row[c] = row[c-1];
                    row[0] = t;
                end
            end
            for (int c = 0; c < nb; c++) o[8*(4*c+r) +: 8] = row[c];
        end
        return o;
    endfunction

    function automatic logic [0:127] ref4(logic inv, logic [0:127] d);
        logic [0:255] w;
        w = ref_shift(4, inv, {d, 128'h0});
        return w[0:127];
    endfunction

    function automatic logic [0:127] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send4(input logic mode, input logic [0:127] d,
                         output logic v, output logic m, output logic [0:127] res);
        in_valid = 1'b1; in_mode = mode; in_data = d;
        step();
        in_valid = 1'b0;
        v = out_valid; m = out_mode; res = out_data;
        step();
    endtask

    task automatic xfer8(input logic mode, input logic [0:255] d, output logic v, output logic [0:255] res);
        v8 = 1'b1; m8 = mode; d8 = d;
        step();
        v8 = 1'b0;
        v = ov8 & (om8 == mode); res = od8;
        step();
    endtask

    task automatic xfer6(input logic mode, input logic [0:191] d, output logic v, output logic [0:191] res);
        v6 = 1'b1; m6 = mode; d6 = d;
        step();
        v6 = 1'b0;
        v = ov6 & (om6 == mode); res = od6;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_data = '0; out_ready = 1'b0;
        v8 = 1'b0; m8 = 1'b0; d8 = '0; v6 = 1'b0; m6 = 1'b0; d6 = '0;
        #2;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_held: got %b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        step(); step();
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_rel: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid_rel: got %b expected 0", out_valid); end
        checks++; if (out_data !== 128'h0 || out_mode !== 1'b0) begin errors++; $display("FAIL reset_out_zero: got %h/%b expected 0/0", out_data, out_mode); end
        step();
    endtask

    task automatic test_known_vectors();
        logic [0:127] a, b, r;
        logic         v, m;
        a = 128'hd42711aee0bf98f1b8b45de51e415230;
        b = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
        out_ready = 1'b1;
        send4(1'b0, a, v, m, r);
        checks++; if (v !== 1'b1 || m !== 1'b0) begin errors++; $display("FAIL fwd_vec_hs: got v=%b m=%b expected v=1 m=0", v, m); end
        checks++; if (r !== b) begin errors++; $display("FAIL fwd_vec: got %h expected %h", r, b); end
        send4(1'b1, b, v, m, r);
        checks++; if (v !== 1'b1 || m !== 1'b1) begin errors++; $display("FAIL inv_vec_hs: got v=%b m=%b expected v=1 m=1", v, m); end
        checks++; if (r !== a) begin errors++; $display("FAIL inv_vec: got %h expected %h", r, a); end
    endtask

    task automatic test_roundtrip();
        logic [0:127] orig, f, back;
        logic         v, m;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            orig = rand128();
            send4(1'b0, orig, v, m, f);
            checks++; if (v !== 1'b1 || f !== ref4(1'b0, orig)) begin errors++; $display("FAIL rt_fwd[%0d]: got v=%b %h expected %h", i, v, f, ref4(1'b0, orig)); end
            send4(1'b1, f, v, m, back);
            checks++; if (v !== 1'b1 || back !== orig) begin errors++; $display("FAIL rt_inv[%0d]: got v=%b %h expected %h", i, v, back, orig); end
        end
    endtask

    task automatic test_wide();
        logic [0:255] a8, r8v, b8, exp8;
        logic [0:191] a6, r6v, exp6;
        logic [0:255] w;
        logic [0:31]  col, ecol;
        logic         v, md;
        for (int k = 0; k < 32; k++) a8[8*k +: 8] = k[7:0];
        xfer8(1'b0, a8, v, r8v);
        col = r8v[0:31]; ecol = 32'h00050e13;
        checks++; if (v !== 1'b1 || col !== ecol) begin errors++; $display("FAIL nb8_col0: got v=%b %h expected %h", v, col, ecol); end
        col = r8v[224:255]; ecol = 32'h1c010a0f;
        checks++; if (col !== ecol) begin errors++; $display("FAIL nb8_col7: got %h expected %h", col, ecol); end
        exp8 = ref_shift(8, 1'b0, a8);
        checks++; if (r8v !== exp8) begin errors++; $display("FAIL nb8_fwd: got %h expected %h", r8v, exp8); end
        xfer8(1'b1, r8v, v, b8);
        checks++; if (v !== 1'b1 || b8 !== a8) begin errors++; $display("FAIL nb8_inv: got v=%b %h expected %h", v, b8, a8); end
        for (int i = 0; i < 4; i++) begin
            md = i[0];
            a8 = {rand128(), rand128()};
            xfer8(md, a8, v, r8v);
            exp8 = ref_shift(8, md, a8);
            checks++; if (v !== 1'b1 || r8v !== exp8) begin errors++; $display("FAIL nb8_rand[%0d]: got v=%b %h expected %h", i, v, r8v, exp8); end
        end
        for (int k = 0; k < 24; k++) a6[8*k +: 8] = k[7:0];
        for (int i = 0; i < 5; i++) begin
            md = (i == 0) ? 1'b0 : i[0];
            if (i > 0) begin
                w = {rand128(), rand128()};
                a6 = w[0:191];
            end
            xfer6(md, a6, v, r6v);
            w = ref_shift(6, md, {a6, 64'h0});
            exp6 = w[0:191];
            checks++; if (v !== 1'b1 || r6v !== exp6) begin errors++; $display("FAIL nb6[%0d]: got v=%b %h expected %h", i, v, r6v, exp6); end
        end
    endtask

    task automatic test_backpressure();
        logic [0:127] blk [3];
        logic [0:127] eq [$];
        logic         mq [$];
        logic [0:127] head0;
        int           n_out;
        for (int i = 0; i < 3; i++) blk[i] = rand128();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = blk[0]; in_mode = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_rdy0: got %b expected 1", in_ready); end
        eq.push_back(ref4(1'b0, blk[0])); mq.push_back(1'b0);
        step();
        in_data = blk[1]; in_mode = 1'b1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_rdy1: got %b expected 1", in_ready); end
        eq.push_back(ref4(1'b1, blk[1])); mq.push_back(1'b1);
        head0 = eq[0];
        step();
        in_data = blk[2]; in_mode = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full[%0d]: got %b expected 0", c, in_ready); end
            checks++; if (out_valid !== 1'b1 || out_data !== head0) begin errors++; $display("FAIL bp_hold[%0d]: got v=%b %h expected %h", c, out_valid, out_data, head0); end
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_out = 0;
        for (int c = 0; c < 5; c++) begin
            if (out_valid) begin
                checks++;
                if (eq.size() == 0) begin
                    errors++; $display("FAIL bp_extra: got %h expected none", out_data);
                end else if (out_data !== eq[0] || out_mode !== mq[0] || c != n_out) begin
                    errors++; $display("FAIL bp_order[%0d]: got %h/%b at cycle %0d expected %h/%b", n_out, out_data, out_mode, c, eq[0], mq[0]);
                end
                if (eq.size() != 0) begin void'(eq.pop_front()); void'(mq.pop_front()); end
                n_out++;
            end
            step();
        end
        checks++; if (n_out != 2) begin errors++; $display("FAIL bp_count: got %0d expected 2", n_out); end
    endtask

    task automatic test_streaming();
        logic [0:127] eq [$];
        logic         mq [$];
        logic [0:127] d;
        int           sent, got;
        sent = 0; got = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 40 && got < 20; c++) begin
            checks++; if (out_valid !== (eq.size() != 0)) begin errors++; $display("FAIL st_valid[%0d]: got %b expected %b", c, out_valid, eq.size() != 0); end
            if (out_valid && eq.size() != 0) begin
                checks++; if (out_data !== eq[0] || out_mode !== mq[0]) begin errors++; $display("FAIL st_data[%0d]: got %h/%b expected %h/%b", got, out_data, out_mode, eq[0], mq[0]); end
                void'(eq.pop_front()); void'(mq.pop_front());
                got++;
            end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL st_ready[%0d]: got %b expected 1", c, in_ready); end
            if (sent < 20) begin
                d = rand128();
                in_valid = 1'b1; in_data = d; in_mode = sent[0];
                if (in_ready) begin
                    eq.push_back(ref4(sent[0], d)); mq.push_back(sent[0]);
                    sent++;
                end
            end else begin
                in_valid = 1'b0;
            end
            step();
        end
        in_valid = 1'b0;
        checks++; if (got != 20) begin errors++; $display("FAIL st_count: got %0d expected 20", got); end
    endtask

    task automatic test_reset_midstream();
        logic [0:127] a, r;
        logic         v, m;
        out_ready = 1'b0;
        in_valid = 1'b1; in_mode = 1'b0; in_data = rand128();
        step();
        in_data = rand128();
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL rm_full: got v=%b r=%b expected v=1 r=0", out_valid, in_ready); end
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_async: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b0 || out_data !== 128'h0) begin errors++; $display("FAIL rm_clear: got r=%b %h expected r=0 0", in_ready, out_data); end
        step();
        #2 rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rm_release: got r=%b v=%b expected r=1 v=0", in_ready, out_valid); end
        step();
        out_ready = 1'b1;
        a = rand128();
        send4(1'b1, a, v, m, r);
        checks++; if (v !== 1'b1 || m !== 1'b1 || r !== ref4(1'b1, a)) begin errors++; $display("FAIL rm_after: got v=%b m=%b %h expected %h", v, m, r, ref4(1'b1, a)); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_no_stale: got %b expected 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_known_vectors();
        test_roundtrip();
        test_wide();
        test_backpressure();
        test_streaming();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule
